// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART engines
//
// Contents:
//   K_W_DEFAULT   default width of the bit-time count
//   FRAME_MAX     longest frame in bits (start + 8 data + parity + stop)
//   BITCNT_W      width of the frame bit counter
//   ST_*          2-bit receive FSM state codes, plus the matching enum
package uart_pkg;

    localparam int K_W_DEFAULT = 19;
    localparam int FRAME_MAX   = 11;
    localparam int BITCNT_W    = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        DONE  = ST_DONE
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable bit-time down-counter with half-bit load and zero flag
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   load       start a full bit interval of 'period' clocks
//   load_half  start a half bit interval of period>>1 clocks
//   period     clocks per bit
//   zero       high during the last clock of the running interval
//
// The counter holds (remaining clocks - 1), so zero marks the final clock of
// an interval and a reload issued on that clock gives back-to-back intervals
// of exactly 'period' clocks with no drift across the frame.
module uart_bit_timer #(
    parameter int K_W = 19
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic           load_half,
    input  logic [K_W-1:0] period,
    output logic           zero
);

    localparam logic [K_W-1:0] ONE = K_W'(1);

    logic [K_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= period - ONE;
        end else if (load_half) begin
            count <= (period >> 1) - ONE;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receive engine: start detect, mid-bit sampling, parity/stop check
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   RX                    serial line, idles high
//   EIGHT, PEN, OHEL      8-bit data / parity enable / odd parity, latched at start
//   k                     clocks per bit (4 .. 2^K_W-1)
//   clr_rdy               read strobe clearing RXRDY, PERR, FERR, OVF
//   data                  received byte, right-justified (bit 7 = 0 in 7-bit mode)
//   RXRDY, PERR, FERR, OVF  frame ready, parity error, framing error, overrun
//
// Build option: UART_RX_SYNC_EN adds a 2-flop synchronizer on RX (+2 clks latency).
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int K_W = K_W_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           RX,
    input  logic           EIGHT,
    input  logic           PEN,
    input  logic           OHEL,
    input  logic [K_W-1:0] k,
    input  logic           clr_rdy,
    output logic [7:0]     data,
    output logic           RXRDY,
    output logic           PERR,
    output logic           FERR,
    output logic           OVF
);

    logic rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], RX};
        end
    end

    assign rx = rx_sync[1];
`else
    assign rx = RX;
`endif

    rx_state_t             state;
    logic                  eight_q;
    logic                  pen_q;
    logic                  ohel_q;
    logic [BITCNT_W-1:0]   bit_cnt;
    logic [BITCNT_W-1:0]   last_cnt;
    logic [FRAME_MAX-2:0]  shift_reg;
    logic                  tick;
    logic                  load_full;
    logic                  load_half;

    uart_bit_timer #(.K_W(K_W)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_full),
        .load_half (load_half),
        .period    (k),
        .zero      (tick)
    );

    always_comb begin
        load_half = (state == IDLE) && !rx;
        load_full = tick && (((state == START) && !rx) || (state == DATA));
    end

    // Bits sampled after the start bit: data + parity + stop. The counter
    // starts at 1 (start bit) so the last sample happens at this value.
    assign last_cnt = BITCNT_W'(8) + BITCNT_W'(eight_q) + BITCNT_W'(pen_q);

    // Frame decode. Samples enter at the top of shift_reg, so the stop bit
    // sits at [9], parity (if any) at [8], and the data bits end just below;
    // shorter frames leave 1 or 2 stale bits at the bottom to drop.
    logic [1:0] drop;
    logic [7:0] frame_bits;
    logic [7:0] data_bits;
    logic       par_bit;
    logic       stop_bit;
    logic       perr_next;

    always_comb begin
        drop       = 2'd2 - 2'(eight_q) - 2'(pen_q);
        frame_bits = 8'(shift_reg >> drop);
        data_bits  = eight_q ? frame_bits : {1'b0, frame_bits[6:0]};
        par_bit    = shift_reg[FRAME_MAX-3];
        stop_bit   = shift_reg[FRAME_MAX-2];
        perr_next  = pen_q && (par_bit != ((^data_bits) ^ ohel_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data      <= '0;
            RXRDY     <= 1'b0;
            PERR      <= 1'b0;
            FERR      <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx) begin
                        eight_q <= EIGHT;
                        pen_q   <= PEN;
                        ohel_q  <= OHEL;
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= BITCNT_W'(1);
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {rx, shift_reg[FRAME_MAX-2:1]};
                        bit_cnt   <= bit_cnt + BITCNT_W'(1);
                        if (bit_cnt == last_cnt) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A read landing on the completion cycle acknowledges the old
            // frame, so the new one is not reported as an overrun.
            if (state == DONE) begin
                data  <= data_bits;
                PERR  <= perr_next;
                FERR  <= ~stop_bit;
                OVF   <= RXRDY & ~clr_rdy;
                RXRDY <= 1'b1;
            end else if (clr_rdy) begin
                RXRDY <= 1'b0;
                PERR  <= 1'b0;
                FERR  <= 1'b0;
                OVF   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - self-checking bench for uart_rx_engine
module tb_uart_rx_engine;

    localparam int K_W = 19;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b1;
    logic           RX      = 1'b1;
    logic           EIGHT   = 1'b1;
    logic           PEN     = 1'b0;
    logic           OHEL    = 1'b0;
    logic [K_W-1:0] k       = K_W'(16);
    logic           clr_rdy = 1'b0;
    logic [7:0]     data;
    logic           RXRDY;
    logic           PERR;
    logic           FERR;
    logic           OVF;

    int n_checks = 0;
    int n_errors = 0;
    int kv       = 16;

    logic [7:0] m_data;
    logic       m_rdy;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovf;

    uart_rx_engine #(.K_W(K_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .RX      (RX),
        .EIGHT   (EIGHT),
        .PEN     (PEN),
        .OHEL    (OHEL),
        .k       (k),
        .clr_rdy (clr_rdy),
        .data    (data),
        .RXRDY   (RXRDY),
        .PERR    (PERR),
        .FERR    (FERR),
        .OVF     (OVF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s.data", tag), int'(data), int'(m_data));
        chk($sformatf("%s.rxrdy", tag), int'(RXRDY), int'(m_rdy));
        chk($sformatf("%s.perr", tag), int'(PERR), int'(m_perr));
        chk($sformatf("%s.ferr", tag), int'(FERR), int'(m_ferr));
        chk($sformatf("%s.ovf", tag), int'(OVF), int'(m_ovf));
    endtask

    task automatic model_clear();
        m_rdy  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_data = 8'h00;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
        model_clear();
    endtask

    // Drives one frame of kv clocks per bit. clr_at pulses clr_rdy in that
    // frame cycle; abort_at pulls reset in that cycle and abandons the frame.
    // rise returns the clock count from the start edge to RXRDY rising.
    task automatic send_frame(input logic [7:0] b, input logic e, input logic pe,
                              input logic oh, input logic pflip, input logic stopb,
                              input int clr_at, input int abort_at, output int rise);
        logic [7:0] db;
        logic       bits[$];
        logic       prev;
        db = e ? b : {1'b0, b[6:0]};
        bits.push_back(1'b0);
        for (int i = 0; i < (e ? 8 : 7); i++) bits.push_back(db[i]);
        if (pe) bits.push_back((^db) ^ oh ^ pflip);
        bits.push_back(stopb);
        k     = K_W'(kv);
        EIGHT = e;
        PEN   = pe;
        OHEL  = oh;
        rise  = -1;
        prev  = RXRDY;
        for (int c = 0; c < bits.size() * kv; c++) begin
            RX      = bits[c / kv];
            clr_rdy = (c == clr_at);
            if (c == abort_at) begin
                reset_n = 1'b0;
                clr_rdy = 1'b0;
                #1;
                model_reset();
                check_all("abort");
                repeat (2) @(posedge clk);
                #1;
                reset_n = 1'b1;
                idle(3);
                return;
            end
            @(posedge clk);
            #1;
            if (rise < 0 && RXRDY && !prev) rise = c + 1;
            prev = RXRDY;
        end
        clr_rdy = 1'b0;
        RX      = 1'b1;
        m_ovf   = m_rdy && (clr_at < 0);
        m_rdy   = 1'b1;
        m_data  = db;
        m_perr  = pe & pflip;
        m_ferr  = ~stopb;
        idle(stopb ? 2 : kv + 6);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r;
        logic [7:0] rb;
        logic re, rp, ro, rf, rs;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        reset_n = 1'b1;
        idle(4);

        kv = 16;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, lat);
        check_all("a5_8n1");
        chk("latency_8n1", (lat >= 152 && lat <= 156) ? 154 : lat, 154);

        pulse_clr();
        send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, r);
        check_all("41_7e1_good");
        pulse_clr();
        send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, r);
        check_all("41_7e1_bad");

        pulse_clr();
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, r);
        check_all("00_8o1_ferr");
        pulse_clr();
        check_all("clr_after_ferr");

        RX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(2 * kv);
        chk("glitch.rxrdy", int'(RXRDY), 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, r);
        check_all("3c_after_glitch");

        pulse_clr();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, r);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, r);
        check_all("ovf_22");
        pulse_clr();
        check_all("clr_all");

        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, r);
        send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat - 1, -1, r);
        check_all("clr_at_done");

        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 4 * kv, r);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, r);
        check_all("5a_after_reset");

        for (int i = 0; i < 40; i++) begin
            kv = $urandom_range(4, 20);
            rb = 8'($urandom_range(0, 255));
            re = 1'($urandom_range(0, 1));
            rp = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            rf = rp ? 1'($urandom_range(0, 1)) : 1'b0;
            rs = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) pulse_clr();
            send_frame(rb, re, rp, ro, rf, rs, -1, -1, r);
            check_all($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Receive half of the full UART and the counterpart of the transmit-side parity/stop encoder.
- Detects a start bit on the serial line, samples each bit at mid-bit using the programmed bit time, and shifts in 7 or 8 data bits, an optional parity bit and the stop bit.
- Presents the right-justified byte with RXRDY, PERR, FERR and OVF status to the UART register interface.

Parameters:
- K_W, 19, width of the bit-time count input k and the internal bit-time counter.

Ports:
- clk  input  1  system clock; single clock domain.
- reset_n  input  1  reset, asynchronous, active-low.
- RX  input  1  serial line; idles high.
- EIGHT  input  1  1 = 8 data bits, 0 = 7 data bits.
- PEN  input  1  parity enable.
- OHEL  input  1  parity sense; 0 = even, 1 = odd.
- k  input  K_W  clocks per bit; legal range 4 to 2^K_W-1.
- clr_rdy  input  1  one-cycle read strobe; clears RXRDY, PERR, FERR and OVF.
- data  output  8  received byte; bit 7 forced to 0 in 7-bit mode.
- RXRDY  output  1  frame available.
- PERR  output  1  parity error on the last frame.
- FERR  output  1  framing error (stop bit sampled 0).
- OVF  output  1  a frame completed while RXRDY was already 1.

Behaviour:
- Reset: async assert sets all outputs, counters and shift register to 0 and the FSM to IDLE. Reset mid-frame abandons the frame with no flags set.
- Config latch: EIGHT, PEN and OHEL are latched on the IDLE->START transition and held constant for the whole frame.
- Frame length: nbits = 1 + (7+EIGHT) + PEN + 1.
- IDLE: stay while RX=1; on RX=0 load bit counter=0, load btc with k>>1, go to START.
- START: decrement btc each clk. At btc==0, resample RX:
  - RX=1: false start; return to IDLE with no flags.
  - RX=0: load btc=k, bit counter=1, go to DATA.
- DATA: decrement btc each clk. At btc==0, shift RX into shift_reg[9] (right shift), increment the bit counter and reload btc=k. When the bit counter reaches nbits-1 after the shift, go to DONE.
- DONE (1 clk): right-justify the shift register per config.
  - Data bits are d[0..6] or d[0..7]; p is the parity bit; s is the stop bit (last sampled).
  - data <= extracted bits.
  - PERR <= PEN & (p != (^data_bits ^ OHEL)).
  - FERR <= ~s.
  - OVF <= RXRDY (the old value).
  - RXRDY <= 1. Go to IDLE.
  - Data and flags update in the same clk.
- Latency: RXRDY rises 1 clk after the stop-bit sample point, i.e. about (nbits-0.5)*k + 2 clks after the falling edge of start.
- clr_rdy:
  - In a cycle without DONE: clears RXRDY, PERR, FERR and OVF next clk.
  - Same cycle as DONE: DONE wins. The new frame sets RXRDY=1, PERR and FERR reflect the new frame, and OVF=0.
- Back-to-back frames: RX=0 seen in IDLE immediately after DONE starts the next frame. There is no dead time beyond the 1-clk DONE.
- A break (RX held 0) completes a frame with data=0 and FERR=1, then re-enters START from IDLE while RX stays 0.

Optional Feature:
- UART_RX_SYNC_EN defined: RX passes through a 2-flop synchronizer, reset to 1 by reset_n, before the FSM. This adds 2 clks to all latencies.
- Undefined: RX is used directly; the input must already be synchronous.

Decomposition:
- Package uart_pkg holds:
  - state encodings IDLE/START/DATA/DONE (2-bit localparams);
  - K_W default;
  - frame constants FRAME_MAX = 11 and BITCNT_W = 4.
- One natural sub-module: uart_bit_timer. It is the loadable down-counter with load value, half-bit load and zero flag, and is reusable by the transmit engine.

Test Plan:
- k=16, 8N1 (EIGHT=1, PEN=0), send 0xA5 -> data=0xA5, RXRDY=1, PERR=FERR=OVF=0, RXRDY rises 154±2 clks after the start edge.
- k=16, 7-bit even parity (EIGHT=0, PEN=1, OHEL=0), send 0x41 with p=0 -> data=0x41, PERR=0. Resend with p=1 -> PERR=1.
- 8-bit odd parity (EIGHT=1, PEN=1, OHEL=1), send 0x00 with p=1 and stop=0 -> data=0x00, PERR=0, FERR=1.
- RX low glitch of 3 clks with k=16 -> FSM returns to IDLE and RXRDY stays 0. A following valid frame of 0x3C is received correctly.
- Two frames 0x11 then 0x22 with no clr_rdy -> data=0x22, OVF=1. Then pulse clr_rdy -> all flags 0 next clk. clr_rdy coincident with DONE -> RXRDY=1, OVF=0.
- Assert reset_n=0 mid-DATA on an 0xFF frame -> all outputs 0 immediately. After release, a fresh 0x5A frame gives data=0x5A with no errors.
